// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
//
// Handshake: the master raises imem_req and holds imem_addr stable for the
// whole request. The slave answers with imem_ack for one or more cycles, and
// imem_rdata is valid in any cycle where imem_ack is high. The master takes
// the first acked cycle and drops imem_req on the following edge. A slave
// ack while imem_req is low is ignored.
//
// Signals:
//   imem_addr  [PC_W-1:0]  master -> slave  fetch address
//   imem_req               master -> slave  request, registered
//   imem_ack               slave  -> master read data valid this cycle
//   imem_rdata [15:0]      slave  -> master read data
interface instr_fetch_unit_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter and instruction register
// and runs single-word fetches over the instruction-memory bus.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   pc_clr            synchronous clear; overrides every other input
//   pc_inc            increment pc now (IDLE) or after the fetch (with i_rd)
//   i_rd              start a fetch from the current pc
//   ir_ld             load the fetched word into the instruction register
//   imem              instruction-memory bus, master side
//   instruction[15:0] instruction register
//   pc[PC_W-1:0]      program counter
//   fetch_busy        high while a request is outstanding
//   fetch_done        one-cycle pulse after an acked fetch
//   fetch_err         sticky timeout flag, cleared only by pc_clr or rst
//   dbg_state[1:0]    current FSM state (0 IDLE, 1 REQ, 2 ERR)
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_clr,
  input  logic                 pc_inc,
  input  logic                 i_rd,
  input  logic                 ir_ld,
  instr_fetch_unit_if.master   imem,
  output logic [15:0]          instruction,
  output logic [PC_W-1:0]      pc,
  output logic                 fetch_busy,
  output logic                 fetch_done,
  output logic                 fetch_err,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0] ERR_OPCODE = 16'hF000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_addr;
  logic [15:0]     r_instr;
  logic            r_req;
  logic            r_done;
  logic            r_err;
  logic            r_pend_ld;
  logic            r_pend_inc;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt counts completed REQ cycles without ack; the edge that would bring
  // it to TIMEOUT is the one that gives up, so imem_req is high for exactly
  // TIMEOUT cycles. An ack in that last cycle is checked first and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_addr     <= '0;
      r_instr    <= 16'h0000;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pend_ld  <= 1'b0;
      r_pend_inc <= 1'b0;
      r_cnt      <= '0;
    end else if (pc_clr) begin
      // Aborts any request; a coincident ack is dropped with it.
      r_state    <= IDLE;
      r_pc       <= '0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pend_ld  <= 1'b0;
      r_pend_inc <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rd) begin
            r_addr     <= r_pc;
            r_pend_ld  <= ir_ld;
            r_pend_inc <= pc_inc;
            r_cnt      <= '0;
            r_req      <= 1'b1;
            r_state    <= REQ;
          end else if (pc_inc) begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        REQ: begin
          if (imem.imem_ack) begin
            if (r_pend_ld)  r_instr <= imem.imem_rdata;
            if (r_pend_inc) r_pc    <= r_pc + PC_W'(1);
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_instr <= ERR_OPCODE;
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ERR: begin
          r_req <= 1'b0;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Latched address during a request, live pc otherwise.
  assign imem.imem_addr = (r_state == REQ) ? r_addr : r_pc;
  assign imem.imem_req  = r_req;
  assign instruction    = r_instr;
  assign pc             = r_pc;
  assign fetch_busy     = r_req;
  assign fetch_done     = r_done;
  assign fetch_err      = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps with a scoreboard queue holding
// the expected {instruction, pc} for each fetch, popped on fetch_done.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_clr;
  logic        pc_inc;
  logic        i_rd;
  logic        ir_ld;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  instr_fetch_unit_if #(.PC_W(8)) imem_bus ();

  instr_fetch_unit #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_clr      (pc_clr),
    .pc_inc      (pc_inc),
    .i_rd        (i_rd),
    .ir_ld       (ir_ld),
    .imem        (imem_bus),
    .instruction (instruction),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic ld, input logic inc, input int waits, input logic [15:0] data);
    int          busy_n;
    logic [23:0] exp_v;
    exp_q.push_back({(ld ? data : m_instr), (inc ? m_pc + 8'd1 : m_pc)});
    i_rd = 1'b1; ir_ld = ld; pc_inc = inc;
    tick();
    i_rd = 1'b0; ir_ld = 1'b0; pc_inc = 1'b0;
    busy_n = 0;
    for (int w = 0; w < waits; w++) begin
      chk("addr_hold", imem_bus.imem_addr, m_pc);
      if (fetch_busy) busy_n++;
      tick();
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    chk("req_at_ack", imem_bus.imem_req, 1'b1);
    chk("addr_at_ack", imem_bus.imem_addr, m_pc);
    if (fetch_busy) busy_n++;
    tick();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'($urandom_range(0, 65535));
    chk("busy_cycles", busy_n, waits + 1);
    chk("done_latency", fetch_done, 1'b1);
    exp_v = exp_q.pop_front();
    if (fetch_done) chk("fetch_result", {instruction, pc}, exp_v);
    {m_instr, m_pc} = exp_v;
    tick();
    chk("done_pulse", fetch_done, 1'b0);
  endtask

  task automatic inc_pc(input int n);
    pc_inc = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      m_pc = m_pc + 8'd1;
    end
    pc_inc = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int req_n;
    rst = 1'b1; pc_clr = 1'b0; pc_inc = 1'b0; i_rd = 1'b0; ir_ld = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 16'h0000;
    m_pc = 8'h00; m_instr = 16'h0000;
    tick(); tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_flags", {imem_bus.imem_req, fetch_busy, fetch_done, fetch_err}, 4'b0000);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    // Immediate increments in IDLE; address follows pc outside REQ.
    inc_pc(5);
    chk("pc_inc_idle", pc, m_pc);
    chk("addr_idle", imem_bus.imem_addr, 8'h05);

    // Zero-wait fetch with load and deferred increment.
    fetch(1'b1, 1'b1, 0, 16'h2123);
    chk("zw_instr", instruction, 16'h2123);
    chk("zw_pc", pc, 8'h06);

    // Five busy cycles, load only.
    fetch(1'b1, 1'b0, 4, 16'h0A10);
    chk("ws_instr", instruction, 16'h0A10);

    // Ack outside REQ is ignored.
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'hFFFF;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("stray_ack_instr", instruction, m_instr);
    chk("stray_ack_done", fetch_done, 1'b0);

    // Increment only, no load.
    fetch(1'b0, 1'b1, 2, 16'hBEEF);

    // Ack on the last allowed cycle wins over the timeout.
    fetch(1'b1, 1'b0, 14, 16'h7777);
    chk("edge_ack_err", fetch_err, 1'b0);
    chk("edge_ack_state", dbg_state, 2'd0);

    // Timeout with no ack.
    i_rd = 1'b1; ir_ld = 1'b0; pc_inc = 1'b1;
    tick();
    i_rd = 1'b0; pc_inc = 1'b0;
    req_n = 0;
    for (int i = 0; i < 40 && imem_bus.imem_req; i++) begin
      req_n++;
      tick();
    end
    chk("to_req_cycles", req_n, 15);
    chk("to_err", fetch_err, 1'b1);
    chk("to_instr", instruction, 16'hF000);
    chk("to_state", dbg_state, 2'd2);
    chk("to_busy", fetch_busy, 1'b0);
    chk("to_pc", pc, m_pc);
    m_instr = 16'hF000;
    i_rd = 1'b1; pc_inc = 1'b1;
    tick(); tick();
    i_rd = 1'b0; pc_inc = 1'b0;
    chk("err_ignore_state", dbg_state, 2'd2);
    chk("err_ignore_req", imem_bus.imem_req, 1'b0);
    chk("err_ignore_pc", pc, m_pc);
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
    m_pc = 8'h00;
    chk("clr_state", dbg_state, 2'd0);
    chk("clr_pc", pc, 8'h00);
    chk("clr_err", fetch_err, 1'b0);
    chk("clr_instr", instruction, m_instr);

    // pc_clr together with i_rd starts nothing.
    inc_pc(3);
    pc_clr = 1'b1; i_rd = 1'b1;
    tick();
    pc_clr = 1'b0; i_rd = 1'b0;
    m_pc = 8'h00;
    chk("clr_rd_state", dbg_state, 2'd0);
    chk("clr_rd_req", imem_bus.imem_req, 1'b0);
    chk("clr_rd_pc", pc, 8'h00);

    // Abort: pc_clr coincident with ack.
    inc_pc(4);
    i_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1;
    tick();
    i_rd = 1'b0; ir_ld = 1'b0; pc_inc = 1'b0;
    chk("abort_in_req", dbg_state, 2'd1);
    pc_clr = 1'b1; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h1234;
    tick();
    pc_clr = 1'b0; imem_bus.imem_ack = 1'b0;
    m_pc = 8'h00;
    chk("abort_instr", instruction, m_instr);
    chk("abort_pc", pc, 8'h00);
    chk("abort_done", fetch_done, 1'b0);
    chk("abort_req", imem_bus.imem_req, 1'b0);
    tick();
    chk("abort_done_late", fetch_done, 1'b0);

    // Wrap from all-ones through a fetch increment.
    inc_pc(255);
    chk("pre_wrap_pc", pc, 8'hFF);
    fetch(1'b1, 1'b1, 1, 16'h3456);
    chk("wrap_pc", pc, 8'h00);

    // Async reset mid-request, then a late ack.
    inc_pc(2);
    i_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1;
    tick();
    i_rd = 1'b0; ir_ld = 1'b0; pc_inc = 1'b0;
    chk("ar_in_req", imem_bus.imem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", dbg_state, 2'd0);
    chk("ar_pc", pc, 8'h00);
    chk("ar_instr", instruction, 16'h0000);
    chk("ar_flags", {imem_bus.imem_req, fetch_busy, fetch_done, fetch_err}, 4'b0000);
    chk("ar_addr", imem_bus.imem_addr, 8'h00);
    #2 rst = 1'b0;
    tick();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h5555;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("late_ack_instr", instruction, 16'h0000);
    chk("late_ack_done", fetch_done, 1'b0);
    chk("late_ack_pc", pc, 8'h00);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
